dmem_responder: RTL and testbench

Data-memory responder for the RISC-V core's load/store port. It accepts one request per transaction over a valid/ready handshake and applies RV32I byte, halfword and word semantics: byte enables on stores, sign or zero extension on loads. It returns one response pulse after a configurable number of wait states. It sits between the core's memory-stage request logic and a word-organised on-chip RAM. It replaces the zero-latency combinational `ReadData` path once the core is made multi-cycle.

---
 rtl/dmem_pkg.sv | 33 +++
 rtl/dmem_lane_align.sv | 60 ++++++
 rtl/dmem_responder.sv | 167 ++++++++++++++++
 tb/tb_dmem_responder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
//   Shared types and constants for the data-memory responder:
//     dmem_state_t : responder FSM states (IDLE, BUSY, RESP)
//     F3_*         : RV32I load/store funct3 encodings
//     WAIT_W       : width of the wait-state counter
//     f3_illegal() : funct3 legality check for loads and stores
// -----------------------------------------------------------------------------
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } dmem_state_t;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   localparam int WAIT_W = 4;

   // Stores only know B/H/W; loads additionally allow BU/HU.
   function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
      logic sized;
      sized = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      if (we) return !sized;
      return !(sized || (f3 == F3_BU) || (f3 == F3_HU));
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// -----------------------------------------------------------------------------
// dmem_lane_align
//   Combinational byte-lane steering between the core's LSB-aligned data and
//   a 32-bit RAM word.
//   Ports:
//     funct3    in  3  : RV32I access size/sign
//     addr_lo   in  2  : byte offset within the word
//     wdata     in  32 : store data, LSB-aligned
//     rword     in  32 : RAM word currently addressed
//     be        out 4  : store byte enables (0 for load-only encodings)
//     wdata_rep out 32 : store data replicated across all lanes
//     ld_data   out 32 : selected byte/halfword shifted down and extended
//   Halfword lane selection uses only addr_lo[1], so a halfword or word at an
//   odd offset naturally lands on the aligned-down location.
// -----------------------------------------------------------------------------
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  be,
   output logic [31:0] wdata_rep,
   output logic [31:0] ld_data
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   always_comb begin
      // NOTE: every output gets a default before the case so no path can
      // leave one unassigned, which would otherwise infer a latch.
      ld_byte   = rword[{addr_lo, 3'b000} +: 8];
      ld_half   = addr_lo[1] ? rword[31:16] : rword[15:0];
      be        = 4'b0000;
      wdata_rep = wdata;
      ld_data   = 32'd0;
      case (funct3)
         F3_B: begin
            be        = 4'b0001 << addr_lo;
            wdata_rep = {4{wdata[7:0]}};
            ld_data   = {{24{ld_byte[7]}}, ld_byte};
         end
         F3_H: begin
            be        = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{wdata[15:0]}};
            ld_data   = {{16{ld_half[15]}}, ld_half};
         end
         F3_W: begin
            be      = 4'b1111;
            ld_data = rword;
         end
         F3_BU:   ld_data = {24'd0, ld_byte};
         F3_HU:   ld_data = {16'd0, ld_half};
         default: ;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Multi-cycle RV32I data-memory responder: accepts one load/store over a
//   valid/ready handshake, waits WAIT_CYCLES, commits the access to a word
//   RAM and returns a one-cycle response pulse.
//   Parameters:
//     DEPTH_WORDS : RAM size in 32-bit words (power of two, >= 4)
//     WAIT_CYCLES : wait states between accept and response (0..15)
//   Ports:
//     clk        in  1  : clock, rising edge
//     reset      in  1  : asynchronous active-low reset
//     req_valid  in  1  : request present
//     req_ready  out 1  : high only in IDLE
//     req_we     in  1  : 1 = store, 0 = load
//     req_funct3 in  3  : RV32I funct3
//     req_addr   in  32 : byte address
//     req_wdata  in  32 : store data, LSB-aligned
//     rsp_valid  out 1  : one-cycle response pulse
//     rsp_rdata  out 32 : extended load data, 0 for stores/errors
//     rsp_err    out 1  : request rejected
//   Build option:
//     DMEM_MISALIGN_ERR_EN : when defined, misaligned H/W accesses are errors;
//                            otherwise they are aligned down and proceed.
// -----------------------------------------------------------------------------
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int                ADDR_W   = $clog2(DEPTH_WORDS);
   localparam logic [31:0]       DEPTH_U  = DEPTH_WORDS;
   localparam logic [WAIT_W-1:0] CNT_INIT = (WAIT_CYCLES > 0) ? WAIT_W'(WAIT_CYCLES - 1) : '0;

   dmem_state_t       state;
   logic [WAIT_W-1:0] cnt;
   logic              l_we;
   logic [2:0]        l_f3;
   logic [31:0]       l_addr;
   logic [31:0]       l_wdata;

   logic [31:0] mem [DEPTH_WORDS];

   // With zero wait states the commit happens on the accept edge itself, so
   // the access is taken straight from the request bus instead of the latches.
   logic        commit;
   logic        c_we;
   logic [2:0]  c_f3;
   logic [31:0] c_addr;
   logic [31:0] c_wdata;
   logic        c_oor;
   logic        c_mis;
   logic        c_err;
   logic [ADDR_W-1:0] idx;
   logic [3:0]  be;
   logic [31:0] wdata_rep;
   logic [31:0] ld_data;
   logic        wr_en;

   assign req_ready = (state == IDLE);

   assign commit  = (state == IDLE) ? (req_valid && (WAIT_CYCLES == 0))
                                    : ((state == BUSY) && (cnt == '0));
   assign c_we    = (state == IDLE) ? req_we     : l_we;
   assign c_f3    = (state == IDLE) ? req_funct3 : l_f3;
   assign c_addr  = (state == IDLE) ? req_addr   : l_addr;
   assign c_wdata = (state == IDLE) ? req_wdata  : l_wdata;

   // Range is judged on the full word index so high addresses never alias.
   assign c_oor = ({2'b00, c_addr[31:2]} >= DEPTH_U);

`ifdef DMEM_MISALIGN_ERR_EN
   assign c_mis = (((c_f3 == F3_H) || (c_f3 == F3_HU)) && c_addr[0])
               || ((c_f3 == F3_W) && (c_addr[1:0] != 2'b00));
`else
   assign c_mis = 1'b0;
`endif

   assign c_err = f3_illegal(c_we, c_f3) || c_oor || c_mis;
   assign idx   = c_addr[ADDR_W+1:2];

   dmem_lane_align u_lane_align (
      .funct3    (c_f3),
      .addr_lo   (c_addr[1:0]),
      .wdata     (c_wdata),
      .rword     (mem[idx]),
      .be        (be),
      .wdata_rep (wdata_rep),
      .ld_data   (ld_data)
   );

   // A store arriving while reset is held must not reach the array.
   assign wr_en = reset && commit && c_we && !c_err;

   // NOTE: the RAM array has no reset; its contents survive reset and only
   // the control path below is cleared.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
         end
      end
   end

   // NOTE: all state is updated with non-blocking assignments so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         l_we      <= 1'b0;
         l_f3      <= 3'd0;
         l_addr    <= 32'd0;
         l_wdata   <= 32'd0;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  l_we    <= req_we;
                  l_f3    <= req_funct3;
                  l_addr  <= req_addr;
                  l_wdata <= req_wdata;
                  if (WAIT_CYCLES == 0) begin
                     state <= RESP;
                  end else begin
                     state <= BUSY;
                     cnt   <= CNT_INIT;
                  end
               end
            end
            BUSY: begin
               if (cnt == '0) state <= RESP;
               else           cnt   <= cnt - 1'b1;
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase

         if (commit) begin
            rsp_valid <= 1'b1;
            rsp_err   <= c_err;
            rsp_rdata <= (c_err || c_we) ? 32'd0 : ld_data;
         end else if (state == RESP) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'd0;
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//   Three responders (WAIT_CYCLES = 1, 0, 3) share the request bus; each has
//   its own req_valid and reset. A byte-addressed reference memory per
//   instance predicts every response from the RV32I access rules.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

   localparam int DEPTH = 64;
   localparam int N_DUT = 3;

   logic        clk = 1'b0;
   logic [2:0]  rst_v;
   logic [2:0]  req_valid;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   wire  [2:0]  req_ready;
   wire  [2:0]  rsp_valid;
   wire  [2:0]  rsp_err;
   wire  [95:0] rsp_rdata_w;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] mem_m [N_DUT][4*DEPTH];

   always #5 clk = ~clk;

   for (genvar g = 0; g < N_DUT; g++) begin : g_dut
      dmem_responder #(
         .DEPTH_WORDS (DEPTH),
         .WAIT_CYCLES (g == 0 ? 1 : (g == 1 ? 0 : 3))
      ) u_dut (
         .clk        (clk),
         .reset      (rst_v[g]),
         .req_valid  (req_valid[g]),
         .req_ready  (req_ready[g]),
         .req_we     (req_we),
         .req_funct3 (req_funct3),
         .req_addr   (req_addr),
         .req_wdata  (req_wdata),
         .rsp_valid  (rsp_valid[g]),
         .rsp_rdata  (rsp_rdata_w[32*g +: 32]),
         .rsp_err    (rsp_err[g])
      );
   end

   function automatic int wait_of(input int d);
      if (d == 0) return 1;
      if (d == 1) return 0;
      return 3;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference: byte-addressed memory, access size from funct3, sign rule
   // from funct3, errors from legality/range/alignment.
   function automatic void model(input int d, input bit we, input bit [2:0] f3,
                                 input bit [31:0] a_in, input bit [31:0] wd,
                                 output bit err, output bit [31:0] rd);
      int        size;
      bit        sgn;
      bit        legal;
      bit [31:0] a;
      bit [31:0] v;
      a = a_in; size = 4; sgn = 1'b0; legal = 1'b1;
      case (f3)
         3'd0:    begin size = 1; sgn = 1'b1; end
         3'd1:    begin size = 2; sgn = 1'b1; end
         3'd2:    size = 4;
         3'd4:    begin size = 1; legal = !we; end
         3'd5:    begin size = 2; legal = !we; end
         default: legal = 1'b0;
      endcase
      err = !legal || ((a >> 2) >= 32'(DEPTH));
      if ((a % 32'(size)) != 0) begin
`ifdef DMEM_MISALIGN_ERR_EN
         err = 1'b1;
`else
         a = a - (a % 32'(size));
`endif
      end
      rd = 32'd0;
      if (err) return;
      if (we) begin
         for (int i = 0; i < size; i++) mem_m[d][a + 32'(i)] = wd[8*i +: 8];
      end else begin
         v = 32'd0;
         for (int i = 0; i < size; i++) v = v | (32'(mem_m[d][a + 32'(i)]) << (8*i));
         if (sgn && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
         rd = v;
      end
   endfunction

   // Called #1 after a rising edge with the target instance idle.
   task automatic txn(input int d, input bit we, input bit [2:0] f3, input bit [31:0] a,
                      input bit [31:0] wd, output bit [31:0] got, output bit gerr);
      bit        exp_err;
      bit [31:0] exp_rd;
      int        lat;
      check("ready_idle", 32'(req_ready[d]), 32'd1);
      req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
      req_valid[d] = 1'b1;
      @(posedge clk); #1;
      req_valid[d] = 1'b0;
      model(d, we, f3, a, wd, exp_err, exp_rd);
      check("ready_busy", 32'(req_ready[d]), 32'd0);
      lat = 0;
      while (!rsp_valid[d] && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check("latency", 32'(lat), 32'(wait_of(d)));
      got  = rsp_rdata_w[32*d +: 32];
      gerr = rsp_err[d];
      check("rsp_err", 32'(gerr), 32'(exp_err));
      check("rsp_rdata", got, exp_rd);
      @(posedge clk); #1;
      check("pulse_end", {29'd0, rsp_valid[d], rsp_err[d], 1'b0}, 32'd0);
      check("rdata_clr", rsp_rdata_w[32*d +: 32], 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      bit [31:0] got;
      bit        gerr;
      bit        exp_err;
      bit [31:0] exp_rd;
      int        first;
      int        second;
      int        n_pulse;
      bit        saw;
      int        d;
      bit [31:0] a;

      rst_v = 3'b000; req_valid = 3'b000;
      req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      rst_v = 3'b111;
      for (int i = 0; i < N_DUT; i++) begin
         check("rst_ready", 32'(req_ready[i]), 32'd1);
         check("rst_valid", 32'(rsp_valid[i]), 32'd0);
         check("rst_rdata", rsp_rdata_w[32*i +: 32], 32'd0);
         check("rst_err", 32'(rsp_err[i]), 32'd0);
      end

      // Fill every word so later loads see defined contents.
      for (int i = 0; i < N_DUT; i++)
         for (int w = 0; w < DEPTH; w++)
            txn(i, 1'b1, 3'd2, 32'(4*w), $urandom, got, gerr);

      // Word store/load.
      txn(0, 1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, got, gerr);
      txn(0, 1'b0, 3'd2, 32'h10, 32'd0, got, gerr);
      check("lw_deadbeef", got, 32'hDEAD_BEEF);
      check("lw_err", 32'(gerr), 32'd0);

      // Byte store and extension.
      txn(0, 1'b1, 3'd0, 32'h13, 32'h0000_0080, got, gerr);
      txn(0, 1'b0, 3'd0, 32'h13, 32'd0, got, gerr);
      check("lb_sext", got, 32'hFFFF_FF80);
      txn(0, 1'b0, 3'd4, 32'h13, 32'd0, got, gerr);
      check("lbu_zext", got, 32'h0000_0080);
      txn(0, 1'b0, 3'd2, 32'h10, 32'd0, got, gerr);
      check("lw_after_sb", got, 32'h80AD_BEEF);

      // Misaligned halfword store.
      txn(0, 1'b1, 3'd1, 32'h11, 32'h1234_ABCD, got, gerr);
`ifdef DMEM_MISALIGN_ERR_EN
      check("sh_mis_err", 32'(gerr), 32'd1);
      txn(0, 1'b0, 3'd2, 32'h10, 32'd0, got, gerr);
      check("sh_mis_nowrite", got, 32'h80AD_BEEF);
`else
      check("sh_mis_err", 32'(gerr), 32'd0);
      txn(0, 1'b0, 3'd5, 32'h10, 32'd0, got, gerr);
      check("lhu_aligned", got, 32'h0000_ABCD);
`endif

      // Range and funct3 errors.
      txn(0, 1'b0, 3'd2, 32'(4*DEPTH), 32'd0, got, gerr);
      check("oor_err", 32'(gerr), 32'd1);
      check("oor_rdata", got, 32'd0);
      txn(0, 1'b1, 3'd4, 32'h10, 32'h5555_5555, got, gerr);
      check("st_f3_err", 32'(gerr), 32'd1);
      txn(0, 1'b0, 3'd2, 32'h10, 32'd0, got, gerr);
`ifdef DMEM_MISALIGN_ERR_EN
      check("st_f3_nowrite", got, 32'h80AD_BEEF);
`else
      check("st_f3_nowrite", got, 32'h80AD_ABCD);
`endif

      // req_valid held through BUSY/RESP: second accept only in next IDLE.
      model(0, 1'b0, 3'd2, 32'h10, 32'd0, exp_err, exp_rd);
      req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10; req_valid[0] = 1'b1;
      @(posedge clk); #1;
      first = -1; second = -1; n_pulse = 0;
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk); #1;
         if (k == 3) req_valid[0] = 1'b0;
         if (rsp_valid[0]) begin
            n_pulse++;
            if (first < 0) first = k;
            else if (second < 0) second = k;
            check("held_rdata", rsp_rdata_w[31:0], exp_rd);
         end
      end
      check("held_pulses", 32'(n_pulse), 32'd2);
      check("held_first", 32'(first), 32'd1);
      check("held_second", 32'(second), 32'd4);

      // Zero wait states.
      txn(1, 1'b1, 3'd2, 32'h8, 32'hCAFE_F00D, got, gerr);
      txn(1, 1'b0, 3'd2, 32'h8, 32'd0, got, gerr);
      check("w0_lw", got, 32'hCAFE_F00D);

      // Reset during BUSY drops the store and gives no response.
      req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h20; req_wdata = 32'h1;
      req_valid[2] = 1'b1;
      @(posedge clk); #1;
      req_valid[2] = 1'b0;
      @(posedge clk); #1;
      rst_v[2] = 1'b0;
      saw = 1'b0;
      #1;
      if (rsp_valid[2]) saw = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         if (rsp_valid[2]) saw = 1'b1;
      end
      rst_v[2] = 1'b1;
      repeat (6) begin
         @(posedge clk); #1;
         if (rsp_valid[2]) saw = 1'b1;
      end
      check("abort_no_rsp", 32'(saw), 32'd0);
      check("abort_ready", 32'(req_ready[2]), 32'd1);
      txn(2, 1'b0, 3'd2, 32'h20, 32'd0, got, gerr);

      // Randomised traffic across all instances.
      for (int n = 0; n < 300; n++) begin
         d = int'($urandom_range(0, N_DUT - 1));
         if ($urandom_range(0, 9) == 0) a = $urandom;
         else a = $urandom_range(0, 4*DEPTH + 7);
         txn(d, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, got, gerr);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
